// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and constants for the accumulator slice
package acc_pkg;

    localparam int ACC_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/accumulator_4bit_if.sv
// rtl/accumulator_4bit_if.sv - operand/result handshake bundle of the accumulator
interface accumulator_4bit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] B;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             C_out;
    logic             V;
    logic             Z;

    modport master (
        output in_valid, op, B, clear, out_ready,
        input  in_ready, out_valid, acc, C_out, V, Z
    );

    modport slave (
        input  in_valid, op, B, clear, out_ready,
        output in_ready, out_valid, acc, C_out, V, Z
    );
endinterface

// File: rtl/add_sub_stage.sv
// rtl/add_sub_stage.sv - combinational add/subtract with carry and signed overflow
module add_sub_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             V
);
    logic [WIDTH-1:0] w_eff_b;
    logic [WIDTH:0]   w_full;

    // Subtract is A + ~B + 1, so the carry-out reads as "no borrow".
    assign w_eff_b = sub ? ~B : B;
    assign w_full  = {1'b0, A} + {1'b0, w_eff_b} + {{WIDTH{1'b0}}, sub};
    assign S       = w_full[WIDTH-1:0];
    assign C_out   = w_full[WIDTH];
    assign V       = (A[WIDTH-1] == w_eff_b[WIDTH-1]) && (w_full[WIDTH-1] != A[WIDTH-1]);
endmodule

// File: rtl/accumulator_4bit.sv
// rtl/accumulator_4bit.sv - handshaked add/sub accumulator; ACC_SATURATE_EN clamps on overflow
module accumulator_4bit
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    accumulator_4bit_if.slave   bus
);
    acc_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_c_out;
    logic             r_v;
    logic             r_z;
    logic             r_out_valid;
    logic             r_op;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_sum;
    logic             w_c_out;
    logic             w_v;
    logic [WIDTH-1:0] w_acc_next;

    add_sub_stage #(.WIDTH(WIDTH)) u_add_sub (
        .A     (r_acc),
        .B     (r_b),
        .sub   (r_op == OP_SUB),
        .S     (w_sum),
        .C_out (w_c_out),
        .V     (w_v)
    );

`ifdef ACC_SATURATE_EN
    // Overflow direction follows the accumulator sign: positive input overflows upward.
    assign w_acc_next = !w_v          ? w_sum :
                        r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                         {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_acc_next = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_c_out     <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b1;
            r_out_valid <= 1'b0;
            r_op        <= OP_ADD;
            r_b         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clear) begin
                        r_acc   <= '0;
                        r_c_out <= 1'b0;
                        r_v     <= 1'b0;
                        r_z     <= 1'b1;
                    end else if (bus.in_valid) begin
                        r_op    <= bus.op;
                        r_b     <= bus.B;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc       <= w_acc_next;
                    r_c_out     <= w_c_out;
                    r_v         <= w_v;
                    r_z         <= (w_acc_next == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !bus.clear;
    assign bus.out_valid = r_out_valid;
    assign bus.acc       = r_acc;
    assign bus.C_out     = r_c_out;
    assign bus.V         = r_v;
    assign bus.Z         = r_z;
endmodule

// File: tb/tb_accumulator_4bit.sv
// tb/tb_accumulator_4bit.sv - directed self-checking bench for accumulator_4bit
module tb_accumulator_4bit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    accumulator_4bit_if #(.WIDTH(4)) bus ();

    accumulator_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [3:0] e_acc, input logic e_c,
                             input logic e_v, input logic e_z);
        check({tag, ".out_valid"}, {7'd0, bus.out_valid}, 8'd1);
        check({tag, ".acc"},       {4'd0, bus.acc},       {4'd0, e_acc});
        check({tag, ".C_out"},     {7'd0, bus.C_out},     {7'd0, e_c});
        check({tag, ".V"},         {7'd0, bus.V},         {7'd0, e_v});
        check({tag, ".Z"},         {7'd0, bus.Z},         {7'd0, e_z});
    endtask

    // Present one operand, check CALC, then the DONE result; leaves the DUT in DONE.
    task automatic start_op(input string tag, input logic op_i, input logic [3:0] b_i,
                            input logic [3:0] e_acc, input logic e_c, input logic e_v,
                            input logic e_z);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op_i;
        bus.B        = b_i;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, ".calc_out_valid"}, {7'd0, bus.out_valid}, 8'd0);
        check({tag, ".calc_in_ready"},  {7'd0, bus.in_ready},  8'd0);
        @(posedge clk); #1;
        check_res(tag, e_acc, e_c, e_v, e_z);
    endtask

    task automatic release_done(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".idle_out_valid"}, {7'd0, bus.out_valid}, 8'd0);
        check({tag, ".idle_in_ready"},  {7'd0, bus.in_ready},  8'd1);
    endtask

    task automatic run_op(input string tag, input logic op_i, input logic [3:0] b_i,
                          input logic [3:0] e_acc, input logic e_c, input logic e_v,
                          input logic e_z);
        start_op(tag, op_i, b_i, e_acc, e_c, e_v, e_z);
        release_done(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.B        = 4'h5;
        #1;
        check({tag, ".in_ready_during_clear"}, {7'd0, bus.in_ready}, 8'd0);
        @(posedge clk); #1;
        check({tag, ".acc"},       {4'd0, bus.acc},       8'd0);
        check({tag, ".Z"},         {7'd0, bus.Z},         8'd1);
        check({tag, ".C_out"},     {7'd0, bus.C_out},     8'd0);
        check({tag, ".V"},         {7'd0, bus.V},         8'd0);
        check({tag, ".out_valid"}, {7'd0, bus.out_valid}, 8'd0);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check({tag, ".still_idle"}, {7'd0, bus.in_ready}, 8'd1);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.B         = 4'h0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.acc",       {4'd0, bus.acc},       8'd0);
        check("rst.Z",         {7'd0, bus.Z},         8'd1);
        check("rst.C_out",     {7'd0, bus.C_out},     8'd0);
        check("rst.V",         {7'd0, bus.V},         8'd0);
        check("rst.out_valid", {7'd0, bus.out_valid}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.in_ready", {7'd0, bus.in_ready}, 8'd1);

        run_op("add2", 1'b0, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0);
        run_op("add5", 1'b0, 4'h5, 4'h7, 1'b0, 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
        run_op("posovf", 1'b0, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0);
`else
        run_op("posovf", 1'b0, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
`endif

        do_clear("clr1");
        run_op("addF",   1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        run_op("wrap",   1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        run_op("borrow", 1'b1, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);

        do_clear("clr2");
        run_op("add8", 1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
        run_op("negovf", 1'b0, 4'h8, 4'h8, 1'b1, 1'b1, 1'b0);
`else
        run_op("negovf", 1'b0, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1);
`endif

        do_clear("clr3");
        start_op("hold", 1'b0, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.clear    = ~i[0];
            bus.B        = 4'h9;
            @(posedge clk); #1;
            check("hold.out_valid", {7'd0, bus.out_valid}, 8'd1);
            check("hold.acc",       {4'd0, bus.acc},       8'd3);
            check("hold.Z",         {7'd0, bus.Z},         8'd0);
            check("hold.in_ready",  {7'd0, bus.in_ready},  8'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        release_done("hold");
        check("hold.acc_after", {4'd0, bus.acc}, 8'd3);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.B        = 4'h4;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        check("rstcalc.acc",       {4'd0, bus.acc},       8'd0);
        check("rstcalc.Z",         {7'd0, bus.Z},         8'd1);
        check("rstcalc.out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("rstcalc.in_ready",  {7'd0, bus.in_ready},  8'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstcalc.no_result", {7'd0, bus.out_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
